gate_arbiter: RTL and testbench
===============================

GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter OPEN_CYCLES, default 4: clk cycles for the door to travel open, and again to travel closed.
REQ-002 Parameter PASS_TIMEOUT, default 16: maximum clk cycles spent waiting for a car to pass.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port entry_req, input, 1: car requests entry; held high until entry_ack or entry_reject.
REQ-006 Port exit_req, input, 1: car requests exit; held high until exit_ack or exit_reject.
REQ-007 Port exit_slot, input, 2: slot index of the exiting car, valid while exit_req is high.
REQ-008 Port detected, input, 1: car present in the gate (ultrasonic, already synchronous).
REQ-009 Ports entry_ack, entry_reject, exit_ack, exit_reject, output, 1 each: one-cycle response pulses.
REQ-010 Port grant_slot, output, 2: slot reserved by the last entry_ack; held until the next entry_ack.
REQ-011 Port slot_status, output, 4: occupancy bitmap; 1 means occupied.
REQ-012 Port free_count, output, 3: number of zeros in slot_status, from 0 to 4.
REQ-013 Port full, output, 1: high exactly when free_count == 0.
REQ-014 Port door_open, output, 1: gate motor open command.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.
REQ-016 Port timeout_err, output, 1: one-cycle pulse when a pass wait expires.

Function
REQ-017 States SHALL be IDLE, OPENING, PASS_WAIT, PASS_CLEAR and CLOSING.
REQ-018 The unit SHALL serve one transaction at a time; requests arriving while busy are held off with no response until IDLE.
REQ-019 Arming: each request input SHALL carry an armed flag.
  - Cleared by that request's ack or reject.
  - Re-set after the request has been sampled low for at least one cycle.
  - Only armed requests are evaluated.
REQ-020 In IDLE, if both armed requests are high, the requester not served last SHALL win.
  - The last-served flag resets to exit, so entry wins the first tie.
  - Rejects do not update the last-served flag.
REQ-021 Entry win, not full:
  - Reserve the lowest-index free slot: set its slot_status bit and load grant_slot.
  - Pulse entry_ack.
  - Go to OPENING.
  - All of these are visible in the cycle after the sampling edge.
REQ-022 Entry win while full: pulse entry_reject, remain in IDLE, leave slot_status unchanged.
REQ-023 Exit win, slot_status[exit_slot] == 1:
  - Latch exit_slot internally.
  - Pulse exit_ack.
  - Go to OPENING.
REQ-024 Exit win, slot_status[exit_slot] == 0: pulse exit_reject and remain in IDLE.
REQ-025 door_open SHALL be high in OPENING, PASS_WAIT and PASS_CLEAR, and low in IDLE and CLOSING.
REQ-026 OPENING SHALL last exactly OPEN_CYCLES cycles, then go to PASS_WAIT.
REQ-027 PASS_WAIT:
  - On detected == 1, go to PASS_CLEAR.
  - After PASS_TIMEOUT cycles without detected, pulse timeout_err and go to CLOSING.
REQ-028 PASS_CLEAR:
  - On detected == 0, go to CLOSING.
  - If detected is still high after PASS_TIMEOUT cycles, pulse timeout_err and go to CLOSING.
  - One timeout counter covers PASS_WAIT and PASS_CLEAR together; it is reset on entering PASS_WAIT.
REQ-029 Occupancy on completion:
  - Exit, detected falling edge seen: clear slot_status of the latched slot on entry to CLOSING.
  - Exit, timeout: leave the slot occupied.
REQ-030 Occupancy on entry timeout: a timeout with no detected ever seen SHALL release the reserved grant_slot bit on entry to CLOSING. A timeout that occurs after detected was seen keeps the reservation.
REQ-031 CLOSING SHALL last exactly OPEN_CYCLES cycles, then go to IDLE.
REQ-032 A new request SHALL be evaluated no earlier than the first IDLE cycle.
REQ-033 free_count and full SHALL be combinational decodes of registered slot_status, consistent in the same cycle.
REQ-034 All counters SHALL saturate or reload; no counter wraps mid-state.

Reset
REQ-035 While reset is high, the unit SHALL be forced asynchronously to the following values:
  - state IDLE, slot_status 0000, grant_slot 00;
  - all pulse outputs, door_open and busy at 0;
  - free_count 4, full 0;
  - counters 0, both armed flags set, last-served flag = exit.
REQ-036 Reset asserted mid-transaction SHALL abort it: door_open falls immediately and all reservations are lost.

Verification
REQ-037 Entry into an empty lot, detected pulsed high for 3 cycles during PASS_WAIT:
  - entry_ack one cycle, grant_slot 0, slot_status 0001, free_count 3.
  - door_open high for 4 + (wait) + 3 cycles, then 4 CLOSING cycles, then IDLE.
REQ-038 Four sequential entries: slot_status reaches 1111 and full = 1. A fifth entry_req produces entry_reject, no door_open and busy = 0.
REQ-039 Entry and exit requested in the same cycle with slot_status 0001 and exit_slot 0:
  - Entry is served first (grant_slot 1); exit is served in the first IDLE cycle after.
  - Final slot_status is 0010.
REQ-040 exit_req with exit_slot 2 while slot_status is 0001: exit_reject; it is not re-evaluated until exit_req has dropped for one cycle.
REQ-041 Entry with detected never high: timeout_err pulses after 4 + 16 cycles, the reserved bit is released (slot_status back to its prior value), and the door closes.
REQ-042 Reset asserted in PASS_WAIT: outputs reach their reset values without a clock edge, and free_count = 4 after release.

Source files
------------

// File: rtl/gate_arbiter.sv
// Parking gate arbiter: one entry/exit transaction at a time, slot bookkeeping, door sequencing.
// Responses appear one cycle after the sampling edge. Requests seen while busy or unarmed get no response.
module gate_arbiter #(
  parameter int OPEN_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic       detected,
  output logic       entry_ack,
  output logic       entry_reject,
  output logic       exit_ack,
  output logic       exit_reject,
  output logic [1:0] grant_slot,
  output logic [3:0] slot_status,
  output logic [2:0] free_count,
  output logic       full,
  output logic       door_open,
  output logic       busy,
  output logic       timeout_err
);

  localparam int MAXC = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_CYCLES - 1);
  localparam logic [CW-1:0] PASS_LAST = CW'(PASS_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, OPENING, PASS_WAIT, PASS_CLEAR, CLOSING} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, pass_inc;
  logic          entry_armed, entry_armed_nx, exit_armed, exit_armed_nx;
  logic          last_exit, last_exit_nx, is_exit, is_exit_nx;
  logic [1:0]    held_slot, held_slot_nx, grant_nx, free_idx;
  logic [3:0]    slot_nx;
  logic          entry_ack_nx, entry_reject_nx, exit_ack_nx, exit_reject_nx, timeout_nx;
  logic          entry_go, exit_go, pick_exit;

  always_comb begin
    free_count = 3'd0;
    free_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      free_count = free_count + {2'b00, ~slot_status[i]};
      if (!slot_status[i]) free_idx = 2'(i);
    end
  end

  assign full      = (free_count == 3'd0);
  assign busy      = (state != IDLE);
  assign door_open = (state == OPENING) || (state == PASS_WAIT) || (state == PASS_CLEAR);

  assign entry_go  = entry_req & entry_armed;
  assign exit_go   = exit_req & exit_armed;
  // On a tie the side not served last wins
  assign pick_exit = exit_go & (~entry_go | ~last_exit);
  // Shared pass timer saturates so a late detect cannot wrap it
  assign pass_inc  = (cnt >= PASS_LAST) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    last_exit_nx    = last_exit;
    is_exit_nx      = is_exit;
    held_slot_nx    = held_slot;
    grant_nx        = grant_slot;
    slot_nx         = slot_status;
    entry_ack_nx    = 1'b0;
    entry_reject_nx = 1'b0;
    exit_ack_nx     = 1'b0;
    exit_reject_nx  = 1'b0;
    timeout_nx      = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pick_exit) begin
          if (slot_status[exit_slot]) begin
            exit_ack_nx  = 1'b1;
            held_slot_nx = exit_slot;
            is_exit_nx   = 1'b1;
            last_exit_nx = 1'b1;
            state_nx     = OPENING;
          end else begin
            exit_reject_nx = 1'b1;
          end
        end else if (entry_go) begin
          if (full) begin
            entry_reject_nx = 1'b1;
          end else begin
            entry_ack_nx      = 1'b1;
            grant_nx          = free_idx;
            slot_nx[free_idx] = 1'b1;
            is_exit_nx        = 1'b0;
            last_exit_nx      = 1'b0;
            state_nx          = OPENING;
          end
        end
      end
      OPENING: begin
        if (cnt == OPEN_LAST) begin
          cnt_nx   = '0;
          state_nx = PASS_WAIT;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      PASS_WAIT: begin
        if (detected) begin
          cnt_nx   = pass_inc;
          state_nx = PASS_CLEAR;
        end else if (cnt >= PASS_LAST) begin
          // Car never showed: an entry gives its reservation back
          timeout_nx = 1'b1;
          cnt_nx     = '0;
          state_nx   = CLOSING;
          if (!is_exit) slot_nx[grant_slot] = 1'b0;
        end else begin
          cnt_nx = pass_inc;
        end
      end
      PASS_CLEAR: begin
        if (!detected) begin
          cnt_nx   = '0;
          state_nx = CLOSING;
          if (is_exit) slot_nx[held_slot] = 1'b0;
        end else if (cnt >= PASS_LAST) begin
          timeout_nx = 1'b1;
          cnt_nx     = '0;
          state_nx   = CLOSING;
        end else begin
          cnt_nx = pass_inc;
        end
      end
      CLOSING: begin
        if (cnt == OPEN_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase

    entry_armed_nx = (entry_ack_nx | entry_reject_nx) ? 1'b0 : (~entry_req | entry_armed);
    exit_armed_nx  = (exit_ack_nx | exit_reject_nx)   ? 1'b0 : (~exit_req | exit_armed);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      entry_armed  <= 1'b1;
      exit_armed   <= 1'b1;
      last_exit    <= 1'b1;
      is_exit      <= 1'b0;
      held_slot    <= 2'd0;
      grant_slot   <= 2'd0;
      slot_status  <= 4'b0000;
      entry_ack    <= 1'b0;
      entry_reject <= 1'b0;
      exit_ack     <= 1'b0;
      exit_reject  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      entry_armed  <= entry_armed_nx;
      exit_armed   <= exit_armed_nx;
      last_exit    <= last_exit_nx;
      is_exit      <= is_exit_nx;
      held_slot    <= held_slot_nx;
      grant_slot   <= grant_nx;
      slot_status  <= slot_nx;
      entry_ack    <= entry_ack_nx;
      entry_reject <= entry_reject_nx;
      exit_ack     <= exit_ack_nx;
      exit_reject  <= exit_reject_nx;
      timeout_err  <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter with a response scoreboard.
module tb_gate_arbiter;

  localparam logic [3:0] K_EACK = 4'b1000;
  localparam logic [3:0] K_EREJ = 4'b0100;
  localparam logic [3:0] K_XACK = 4'b0010;
  localparam logic [3:0] K_XREJ = 4'b0001;

  logic       clk, reset, entry_req, exit_req, detected;
  logic [1:0] exit_slot, grant_slot;
  logic       entry_ack, entry_reject, exit_ack, exit_reject;
  logic [3:0] slot_status;
  logic [2:0] free_count;
  logic       full, door_open, busy, timeout_err;
  logic [3:0] pulses;

  typedef struct packed {
    logic [3:0] kind;
    logic [1:0] slot;
  } resp_t;

  resp_t sb[$];
  resp_t exp_r;
  int    n_cmp = 0;
  int    n_err = 0;

  gate_arbiter #(.OPEN_CYCLES(4), .PASS_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .detected(detected), .entry_ack(entry_ack),
    .entry_reject(entry_reject), .exit_ack(exit_ack), .exit_reject(exit_reject),
    .grant_slot(grant_slot), .slot_status(slot_status), .free_count(free_count),
    .full(full), .door_open(door_open), .busy(busy), .timeout_err(timeout_err)
  );

  assign pulses = {entry_ack, entry_reject, exit_ack, exit_reject};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard whenever the DUT emits a response pulse
  always @(negedge clk) begin
    if (!reset && pulses != 4'b0000) begin
      chk("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        chk("resp_kind", 32'(pulses), 32'(exp_r.kind));
        if (exp_r.kind == K_EACK) chk("grant_slot", 32'(grant_slot), 32'(exp_r.slot));
      end
    end
  end

  task automatic wait_resp(output logic [3:0] got);
    int n;
    n = 0;
    got = 4'b0000;
    while (n < 40 && got == 4'b0000) begin
      @(negedge clk);
      got = pulses;
      n++;
    end
    chk("resp_arrived", 32'(got != 4'b0000), 32'd1);
  endtask

  // Called on the first OPENING cycle (index 1); detected is driven high for cycles [det_at, det_at+det_len)
  task automatic run_pass(input int det_at, input int det_len,
                          output int door_n, output int close_n, output int tmo_n, output int tmo_idx);
    int i;
    door_n = 0; close_n = 0; tmo_n = 0; tmo_idx = 0;
    i = 1;
    while (busy && i < 200) begin
      if (door_open) door_n++; else close_n++;
      if (timeout_err) begin tmo_n++; tmo_idx = i; end
      detected = (i >= det_at) && (i < det_at + det_len);
      @(negedge clk);
      i++;
    end
    detected = 1'b0;
    chk("pass_done", 32'(busy), 32'd0);
  endtask

  logic [3:0] got;
  int dn, cn, tn, ti, held;
  int gtab[3] = '{0, 2, 3};

  initial begin
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0; detected = 1'b0;
    @(negedge clk);
    chk("rst_slot", 32'(slot_status), 32'h0);
    chk("rst_grant", 32'(grant_slot), 32'h0);
    chk("rst_free", 32'(free_count), 32'd4);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({pulses, timeout_err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Entry into empty lot, car present for 3 cycles after 2 wait cycles
    sb.push_back('{K_EACK, 2'd0});
    entry_req = 1'b1;
    wait_resp(got);
    entry_req = 1'b0;
    chk("e1_slot", 32'(slot_status), 32'b0001);
    chk("e1_free", 32'(free_count), 32'd3);
    chk("e1_door", 32'(door_open), 32'd1);
    chk("e1_busy", 32'(busy), 32'd1);
    run_pass(6, 3, dn, cn, tn, ti);
    chk("e1_door_cycles", 32'(dn), 32'd9);
    chk("e1_close_cycles", 32'(cn), 32'd4);
    chk("e1_tmo", 32'(tn), 32'd0);
    chk("e1_final_slot", 32'(slot_status), 32'b0001);

    // Exit from empty slot is rejected and not re-evaluated while held
    sb.push_back('{K_XREJ, 2'd0});
    exit_slot = 2'd2; exit_req = 1'b1;
    wait_resp(got);
    held = 0;
    repeat (5) begin
      @(negedge clk);
      if (pulses != 4'b0000 || busy) held++;
    end
    chk("xrej_held_off", 32'(held), 32'd0);
    exit_req = 1'b0;
    @(negedge clk);
    sb.push_back('{K_XREJ, 2'd0});
    exit_req = 1'b1;
    wait_resp(got);
    exit_req = 1'b0;
    chk("xrej_slot", 32'(slot_status), 32'b0001);

    // Entry where the car never arrives: reservation released
    sb.push_back('{K_EACK, 2'd1});
    entry_req = 1'b1;
    wait_resp(got);
    entry_req = 1'b0;
    chk("etmo_reserved", 32'(slot_status), 32'b0011);
    run_pass(0, 0, dn, cn, tn, ti);
    chk("etmo_door_cycles", 32'(dn), 32'd20);
    chk("etmo_pulses", 32'(tn), 32'd1);
    chk("etmo_when", 32'(ti), 32'd21);
    chk("etmo_slot", 32'(slot_status), 32'b0001);

    // Exit that times out keeps the slot occupied
    sb.push_back('{K_XACK, 2'd0});
    exit_slot = 2'd0; exit_req = 1'b1;
    wait_resp(got);
    exit_req = 1'b0;
    run_pass(0, 0, dn, cn, tn, ti);
    chk("xtmo_pulses", 32'(tn), 32'd1);
    chk("xtmo_slot", 32'(slot_status), 32'b0001);

    // Simultaneous entry and exit, exit served last: entry wins
    sb.push_back('{K_EACK, 2'd1});
    sb.push_back('{K_XACK, 2'd0});
    exit_slot = 2'd0; entry_req = 1'b1; exit_req = 1'b1;
    wait_resp(got);
    chk("tie_winner", 32'(got), 32'(K_EACK));
    entry_req = 1'b0;
    run_pass(5, 1, dn, cn, tn, ti);
    chk("tie_entry_slot", 32'(slot_status), 32'b0011);
    chk("tie_idle_no_resp", 32'(pulses), 32'd0);
    @(negedge clk);
    chk("tie_exit_next", 32'(exit_ack), 32'd1);
    exit_req = 1'b0;
    run_pass(5, 1, dn, cn, tn, ti);
    chk("tie_final_slot", 32'(slot_status), 32'b0010);

    // Fill the lot, then a fifth entry is rejected
    foreach (gtab[k]) begin
      sb.push_back('{K_EACK, 2'(gtab[k])});
      entry_req = 1'b1;
      wait_resp(got);
      entry_req = 1'b0;
      run_pass(5, 1, dn, cn, tn, ti);
    end
    chk("fill_slot", 32'(slot_status), 32'b1111);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_free", 32'(free_count), 32'd0);
    sb.push_back('{K_EREJ, 2'd0});
    entry_req = 1'b1;
    wait_resp(got);
    chk("rej_door", 32'(door_open), 32'd0);
    chk("rej_busy", 32'(busy), 32'd0);
    entry_req = 1'b0;
    @(negedge clk);
    chk("rej_slot", 32'(slot_status), 32'b1111);

    // Reset in the middle of a pass wait
    sb.push_back('{K_XACK, 2'd0});
    exit_slot = 2'd1; exit_req = 1'b1;
    wait_resp(got);
    exit_req = 1'b0;
    run_pass(5, 1, dn, cn, tn, ti);
    chk("x1_slot", 32'(slot_status), 32'b1101);
    sb.push_back('{K_EACK, 2'd1});
    entry_req = 1'b1;
    wait_resp(got);
    entry_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("pw_door", 32'(door_open), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_door", 32'(door_open), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_slot", 32'(slot_status), 32'h0);
    chk("arst_free", 32'(free_count), 32'd4);
    chk("arst_grant", 32'(grant_slot), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_free", 32'(free_count), 32'd4);
    sb.push_back('{K_EACK, 2'd0});
    entry_req = 1'b1;
    wait_resp(got);
    entry_req = 1'b0;
    run_pass(5, 1, dn, cn, tn, ti);
    chk("post_rst_slot", 32'(slot_status), 32'b0001);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
